// File: rtl/mux_161_rr_arbiter_pkg.sv
// Shared constants for the 16:1 round-robin mux arbiter: sizes, state codes, helpers.
package mux_161_rr_arbiter_pkg;

    localparam int ARB_N    = 16;
    localparam int ARB_SELW = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    function automatic logic [ARB_N-1:0] onehot16(input logic [ARB_SELW-1:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/mux_161_rr_arbiter_if.sv
// Requester-side bundle of the shared mux: requests, data bits, grant and steered output.
interface mux_161_rr_arbiter_if;
    import mux_161_rr_arbiter_pkg::*;

    logic [ARB_N-1:0]    req;
    logic [ARB_N-1:0]    data_i;
    logic [ARB_N-1:0]    gnt;
    logic [ARB_SELW-1:0] sel;
    logic                busy;
    logic                data_o;

    modport master (output req, data_i, input gnt, sel, busy, data_o);
    modport slave  (input req, data_i, output gnt, sel, busy, data_o);

endinterface

// File: rtl/mux_161_rr_arbiter_pick.sv
// Combinational round-robin pick: first eligible request at or above start, wrapping past 15.
module rr_pick16 (
    input  logic [15:0] req,
    input  logic [15:0] mask,
    input  logic [3:0]  start,
    output logic        found,
    output logic [3:0]  idx
);

    logic [15:0] eligible;
    logic [15:0] rotated;
    logic [3:0]  offset;

    assign eligible = req & ~mask;
    // shift by 16 when start==0 yields zero, leaving the plain right-shift term
    assign rotated  = (eligible >> start) | (eligible << (5'd16 - {1'b0, start}));

    always_comb begin
        offset = '0;
        for (int i = 15; i >= 0; i--) begin
            if (rotated[i]) offset = 4'(i);
        end
    end

    assign found = |eligible;
    assign idx   = offset + start;

endmodule

// File: rtl/mux_161_rr_arbiter.sv
// Round-robin owner sequencer for a shared 16:1 one-bit mux with bounded burst length.
//   state | meaning
//   IDLE  | no owner; grant first request after the last owner
//   GRANT | sel owns the mux; release on req drop or burst limit
module mux_161_rr_arbiter
    import mux_161_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_161_rr_arbiter_if.slave   bus
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic [0:0]          state;
    logic [7:0]          cnt;
    logic [ARB_SELW-1:0] last;
    logic [ARB_N-1:0]    gnt_r;
    logic [ARB_SELW-1:0] sel_r;
    logic                busy_r;

    logic                in_grant;
    logic                release_own;
    logic [ARB_N-1:0]    pick_mask;
    logic [ARB_SELW-1:0] pick_start;
    logic [ARB_SELW-1:0] pick_idx;
    logic                pick_found;

    assign in_grant    = (state == GRANT);
    assign release_own = in_grant && (!bus.req[sel_r] || cnt == BURST_LIMIT);
    // while owning, the owner is masked and the scan begins just above it
    assign pick_mask   = in_grant ? onehot16(sel_r) : '0;
    assign pick_start  = in_grant ? sel_r + 4'd1 : last + 4'd1;

    rr_pick16 u_pick (
        .req   (bus.req),
        .mask  (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 4'd15;
            gnt_r  <= '0;
            sel_r  <= '0;
            busy_r <= 1'b0;
        end else if (!in_grant) begin
            if (pick_found) begin
                state  <= GRANT;
                gnt_r  <= onehot16(pick_idx);
                sel_r  <= pick_idx;
                busy_r <= 1'b1;
                cnt    <= 8'd1;
            end
        end else if (release_own) begin
            last <= sel_r;
            if (pick_found) begin
                gnt_r <= onehot16(pick_idx);
                sel_r <= pick_idx;
                cnt   <= 8'd1;
            end else if (bus.req[sel_r]) begin
                cnt <= 8'd1;
            end else begin
                state  <= IDLE;
                gnt_r  <= '0;
                busy_r <= 1'b0;
                cnt    <= '0;
            end
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.sel    = sel_r;
    assign bus.busy   = busy_r;
    assign bus.data_o = bus.data_i[sel_r] & busy_r;

endmodule

// File: tb/tb_mux_161_rr_arbiter.sv
// Directed bench for the 16:1 round-robin mux arbiter, burst limits 8 and 4.
module tb_mux_161_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_161_rr_arbiter_if bus8 ();
    mux_161_rr_arbiter_if bus4 ();

    mux_161_rr_arbiter #(.MAX_BURST(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    mux_161_rr_arbiter #(.MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        bus8.req = '0; bus8.data_i = '0;
        bus4.req = '0; bus4.data_i = '0;
        #2;
        chk("rst_gnt8",  bus8.gnt, 16'h0000);
        chk("rst_sel8",  16'(bus8.sel), 16'h0000);
        chk("rst_busy8", 16'(bus8.busy), 16'h0000);
        chk("rst_gnt4",  bus4.gnt, 16'h0000);
        step; step;
        rst = 1'b0;
        step;
        chk("idle_gnt", bus8.gnt, 16'h0000);

        // single short transfer by requester 5
        bus8.req = 16'h0020;
        for (int k = 0; k < 3; k++) begin
            step;
            chk("t2_gnt",  bus8.gnt, 16'h0020);
            chk("t2_sel",  16'(bus8.sel), 16'h0005);
            chk("t2_busy", 16'(bus8.busy), 16'h0001);
        end
        bus8.req = '0;
        step;
        chk("t2_rel_gnt",  bus8.gnt, 16'h0000);
        chk("t2_rel_busy", 16'(bus8.busy), 16'h0000);
        chk("t2_rel_sel",  16'(bus8.sel), 16'h0005);

        // data steering through owner 9
        bus8.req = 16'h0200;
        step;
        chk("t6_gnt", bus8.gnt, 16'h0200);
        chk("t6_sel", 16'(bus8.sel), 16'h0009);
        bus8.data_i = 16'h0200; #1;
        chk("t6_d_b9hi", 16'(bus8.data_o), 16'h0001);
        bus8.data_i = 16'hFDFF; #1;
        chk("t6_d_others", 16'(bus8.data_o), 16'h0000);
        bus8.data_i = 16'hFFFF; #1;
        chk("t6_d_all", 16'(bus8.data_o), 16'h0001);
        bus8.req = '0;
        step;
        chk("t6_idle_busy", 16'(bus8.busy), 16'h0000);
        chk("t6_idle_d", 16'(bus8.data_o), 16'h0000);
        bus8.data_i = '0;

        // wrap from owner 15 to 0 then 1
        bus8.req = 16'h8000;
        step;
        chk("t4_gnt15", bus8.gnt, 16'h8000);
        chk("t4_sel15", 16'(bus8.sel), 16'h000F);
        bus8.req = 16'h0003;
        step;
        chk("t4_gnt0", bus8.gnt, 16'h0001);
        chk("t4_sel0", 16'(bus8.sel), 16'h0000);
        step;
        chk("t4_hold0", bus8.gnt, 16'h0001);
        bus8.req = 16'h0002;
        step;
        chk("t4_gnt1", bus8.gnt, 16'h0002);
        chk("t4_sel1", 16'(bus8.sel), 16'h0001);
        bus8.req = '0;
        step;
        chk("t4_idle", bus8.gnt, 16'h0000);

        // lone requester 10 across two burst expiries
        bus8.req = 16'h0400;
        for (int k = 0; k < 20; k++) begin
            step;
            chk("t5_gnt", bus8.gnt, 16'h0400);
            chk("t5_sel", 16'(bus8.sel), 16'h000A);
        end
        bus8.req = '0;
        step;
        chk("t5_rel", bus8.gnt, 16'h0000);

        // asynchronous reset in the middle of a grant
        bus8.req = 16'($urandom_range(1, 16'hFFFF));
        bus8.data_i = 16'hFFFF;
        step;
        chk("t1_pre_busy", 16'(bus8.busy), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_gnt",  bus8.gnt, 16'h0000);
        chk("t1_sel",  16'(bus8.sel), 16'h0000);
        chk("t1_busy", 16'(bus8.busy), 16'h0000);
        chk("t1_dout", 16'(bus8.data_o), 16'h0000);
        step;
        bus8.req = 16'h8001;
        bus8.data_i = '0;
        rst = 1'b0;
        step;
        chk("t1_ptr_gnt", bus8.gnt, 16'h0001);

        // alternation under burst limit 4
        bus4.req = 16'h8001;
        for (int k = 0; k < 16; k++) begin
            step;
            chk("t3_gnt",  bus4.gnt, ((k / 4) % 2 == 0) ? 16'h0001 : 16'h8000);
            chk("t3_busy", 16'(bus4.busy), 16'h0001);
        end
        bus4.req = '0;
        bus8.req = '0;
        step;
        chk("t3_idle", bus4.gnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
